pe_psum_drain: RTL and testbench
================================

Name: pe_psum_drain

Overview:
Consumer end of the PE partial-sum interface. It takes the eight per-cycle partial sums psm_0..psm_7 from a PE and accumulates them per output channel across one tile. When the tile completes, it latches the eight totals into an output buffer and serializes them one channel per beat on a valid/ready stream toward the output-feature-map writer. Sits directly downstream of pe, one instance per PE.

Parameters:
PSUM_W, 32, width of each incoming signed partial sum
ACC_W, 40, width of each signed accumulator and of out_data; must be >= PSUM_W
TILE_CNT_W, 16, width of the completed-tile counter

Ports:
clock_pe  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
psm_0 .. psm_7  input  PSUM_W each  signed partial sums for channels 0..7
psm_valid  input  1  psm_0..psm_7 and psm_last valid this cycle
psm_last  input  1  this beat is the final beat of the current tile
psm_ready  output  1  block accepts a beat this cycle
out_data  output  ACC_W  signed accumulated result for channel out_ch
out_ch  output  3  channel index of out_data
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  downstream accepts out beat
tile_cnt  output  TILE_CNT_W  number of tiles fully drained, wraps
sat_flag  output  1  sticky: some accumulation saturated since reset

Behaviour:
- Reset (reset=0, async): all accumulators 0, first=1, buf_full=0, drain FSM IDLE, out_valid=0, out_data=0, out_ch=0, tile_cnt=0, sat_flag=0. A reset mid-tile or mid-drain discards all data.
- Input handshake: a beat is accepted when psm_valid & psm_ready.
- psm_ready = ~(buf_full & psm_last). Non-last beats are always accepted. A last beat stalls while the previous tile is still draining.
- Accumulate on an accepted beat, for each channel i:
  - If first=1: acc_i = sext(psm_i).
  - Else: acc_i = sat(acc_i + sext(psm_i)).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sat_flag.
  - first is cleared after a non-last beat and set after a last beat.
- Tile close: on an accepted last beat, the eight final sums (including that beat's contribution, saturated) are written to buf[0..7] and buf_full is set. Accumulators are not needed further because first=1.
- Single-beat tile: psm_last=1 with first=1 yields buf_i = sext(psm_i).
- Drain FSM:
  - IDLE: when buf_full=1, go to SEND with ch=0.
  - SEND: out_valid=1, out_ch=ch, out_data=buf[ch].
    - On out_valid & out_ready with ch<7: ch increments.
    - On handshake with ch=7: buf_full clears, tile_cnt increments (wraps at 2^TILE_CNT_W), and the FSM returns to IDLE.
- Latency: last beat accepted at cycle N -> out_valid=1, out_ch=0 at cycle N+1. With out_ready held at 1, channel 7 is presented at N+8 and buf_full clears at the N+8 edge.
- Back-to-back tiles: the earliest next tile's last beat is accepted the cycle after the channel-7 handshake. psm_ready is computed from registered buf_full, so there is no same-cycle bypass.
- out_data and out_ch are held stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake.
- psm_* inputs are ignored when not accepted. Accumulation continues during a drain for non-last beats.

Optional Feature:
Macro PE_DRAIN_RELU_EN.
- Defined: values written to buf at tile close pass through ReLU (negative -> 0). sat_flag still reflects saturation before ReLU.
- Undefined: buf holds signed saturated sums unchanged.
- Timing and handshakes are identical in both builds.

Test Plan:
- Reset, then a 3-beat tile with psm_i = i+1 each beat and out_ready=1 -> out_ch 0..7 carry 3,6,...,24 on cycles N+1..N+8; tile_cnt=1.
- Single-beat tile, psm_3 = -5 (others 0) -> out_data = -5 on ch3 (0 when PE_DRAIN_RELU_EN is defined); others 0.
- Accumulate psm_0 = 2^31-1 for 300 beats with ACC_W=40 -> ch0 = 2^39-1 (clamped); sat_flag=1 and stays 1 after the next clean tile.
- Hold out_ready=0 for 5 cycles after out_valid rises, then present a second last beat -> out_data/out_ch stable at ch0; psm_ready=0 while psm_last=1; second tile's last beat accepted the cycle after the ch7 handshake; both tiles' results correct, tile_cnt=2.
- Assert reset mid-drain at ch4 -> out_valid=0, tile_cnt=0 immediately; the next tile's first beat is treated as first (no stale accumulation).
- Random psm_valid/out_ready toggling over 1000 tiles versus a reference model -> all 8000 outputs match, in order, with no drops or duplicates.

Source files
------------

// File: rtl/pe_psum_drain_if.sv
// +----------------------------------------------------------------------------+
// | pe_psum_if / pe_out_if : partial-sum input bundle and drained output stream  |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pe_psum_if #(
  parameter int PSUM_W = 32
);
  logic signed [PSUM_W-1:0] psm_0;
  logic signed [PSUM_W-1:0] psm_1;
  logic signed [PSUM_W-1:0] psm_2;
  logic signed [PSUM_W-1:0] psm_3;
  logic signed [PSUM_W-1:0] psm_4;
  logic signed [PSUM_W-1:0] psm_5;
  logic signed [PSUM_W-1:0] psm_6;
  logic signed [PSUM_W-1:0] psm_7;
  logic                     psm_valid;
  logic                     psm_last;
  logic                     psm_ready;

  modport master (
    output psm_0, psm_1, psm_2, psm_3, psm_4, psm_5, psm_6, psm_7,
    output psm_valid, psm_last,
    input  psm_ready
  );

  modport slave (
    input  psm_0, psm_1, psm_2, psm_3, psm_4, psm_5, psm_6, psm_7,
    input  psm_valid, psm_last,
    output psm_ready
  );
endinterface

interface pe_out_if #(
  parameter int ACC_W = 40
);
  logic signed [ACC_W-1:0] out_data;
  logic [2:0]              out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output out_data, out_ch, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_ch, out_valid,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/pe_psum_drain.sv
// +----------------------------------------------------------------------------+
// | pe_psum_drain : per-channel tile accumulator with serialized 8-beat drain.   |
// | Optional macro PE_DRAIN_RELU_EN clamps negative tile totals to zero.         |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module pe_psum_drain #(
  parameter int PSUM_W     = 32,
  parameter int ACC_W      = 40,
  parameter int TILE_CNT_W = 16
) (
  input  wire                   clock_pe,
  input  wire                   reset,
  pe_psum_if.slave              psm_if,
  pe_out_if.master              out_if,
  output logic [TILE_CNT_W-1:0] tile_cnt,
  output logic                  sat_flag
);

  localparam int c_NCH = 8;
  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              ch_q, ch_d;
  logic                    buf_full_q, buf_full_d;
  logic [TILE_CNT_W-1:0]   tile_cnt_q, tile_cnt_d;
  logic                    first_q;
  logic                    sat_flag_q;
  logic [ACC_W-1:0]        acc_q [c_NCH];
  logic [ACC_W-1:0]        buf_q [c_NCH];
  logic [ACC_W-1:0]        acc_d [c_NCH];
  logic [ACC_W-1:0]        buf_d [c_NCH];
  logic [c_NCH-1:0]        w_ovf;
  logic signed [PSUM_W-1:0] w_psm [c_NCH];
  logic                    w_accept;
  logic                    w_close;
  logic                    w_out_valid;

  assign w_psm[0] = psm_if.psm_0;
  assign w_psm[1] = psm_if.psm_1;
  assign w_psm[2] = psm_if.psm_2;
  assign w_psm[3] = psm_if.psm_3;
  assign w_psm[4] = psm_if.psm_4;
  assign w_psm[5] = psm_if.psm_5;
  assign w_psm[6] = psm_if.psm_6;
  assign w_psm[7] = psm_if.psm_7;

  // Only a closing beat can collide with an occupied buffer; no bypass on drain exit.
  assign psm_if.psm_ready = ~(buf_full_q & psm_if.psm_last);
  assign w_accept         = psm_if.psm_valid & psm_if.psm_ready;
  assign w_close          = w_accept & psm_if.psm_last;

  for (genvar g = 0; g < c_NCH; g++) begin : g_ch
    logic [ACC_W:0] w_sum;
    assign w_sum = (first_q ? {(ACC_W+1){1'b0}} : {acc_q[g][ACC_W-1], acc_q[g]})
                 + {{(ACC_W+1-PSUM_W){w_psm[g][PSUM_W-1]}}, w_psm[g]};
    assign w_ovf[g] = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign acc_d[g] = w_ovf[g] ? (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX)
                               : w_sum[ACC_W-1:0];
`ifdef PE_DRAIN_RELU_EN
    assign buf_d[g] = acc_d[g][ACC_W-1] ? {ACC_W{1'b0}} : acc_d[g];
`else
    assign buf_d[g] = acc_d[g];
`endif
  end

  always_ff @(posedge clock_pe or negedge reset) begin
    if (!reset) begin
      first_q    <= 1'b1;
      sat_flag_q <= 1'b0;
      for (int i = 0; i < c_NCH; i++) begin
        acc_q[i] <= '0;
        buf_q[i] <= '0;
      end
    end else if (w_accept) begin
      first_q <= psm_if.psm_last;
      if (|w_ovf) begin
        sat_flag_q <= 1'b1;
      end
      for (int i = 0; i < c_NCH; i++) begin
        acc_q[i] <= acc_d[i];
        if (psm_if.psm_last) begin
          buf_q[i] <= buf_d[i];
        end
      end
    end
  end

  always_ff @(posedge clock_pe or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      buf_full_q <= 1'b0;
      tile_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      buf_full_q <= buf_full_d;
      tile_cnt_q <= tile_cnt_d;
    end
  end

  // Leaving IDLE on the closing beat itself gives the one-cycle close-to-ch0 latency.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    buf_full_d  = buf_full_q;
    tile_cnt_d  = tile_cnt_q;
    w_out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (buf_full_q | w_close) begin
          state_d = S_SEND;
          ch_d    = 3'd0;
        end
      end
      S_SEND: begin
        w_out_valid = 1'b1;
        if (out_if.out_ready) begin
          if (ch_q == 3'd7) begin
            state_d    = S_IDLE;
            ch_d       = 3'd0;
            buf_full_d = 1'b0;
            tile_cnt_d = tile_cnt_q + {{(TILE_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (w_close) begin
      buf_full_d = 1'b1;
    end
  end

  assign out_if.out_valid = w_out_valid;
  assign out_if.out_ch    = ch_q;
  assign out_if.out_data  = (state_q == S_SEND) ? buf_q[ch_q] : '0;
  assign tile_cnt         = tile_cnt_q;
  assign sat_flag         = sat_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_psum_drain.sv
// Randomized and directed bench for pe_psum_drain against a queue-based reference model.
`default_nettype none

module tb_pe_psum_drain;
  localparam int PSUM_W     = 32;
  localparam int ACC_W      = 40;
  localparam int TILE_CNT_W = 16;
  localparam longint HI = (64'sd1 <<< (ACC_W-1)) - 64'sd1;
  localparam longint LO = -(64'sd1 <<< (ACC_W-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_psum_if #(.PSUM_W(PSUM_W)) ifp ();
  pe_out_if  #(.ACC_W(ACC_W))   ifo ();
  logic [TILE_CNT_W-1:0] tile_cnt;
  logic                  sat_flag;

  pe_psum_drain #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .TILE_CNT_W(TILE_CNT_W)) dut (
    .clock_pe (clk),
    .reset    (rst_n),
    .psm_if   (ifp),
    .out_if   (ifo),
    .tile_cnt (tile_cnt),
    .sat_flag (sat_flag)
  );

  typedef struct {
    int     ch;
    longint data;
    int     cyc;
  } beat_t;

  beat_t  mq[$];
  beat_t  seen[$];
  longint macc [8];
  bit     mfirst;
  int     mtile;
  bit     msat;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  bit drv_valid = 0, drv_last = 0, drv_ordy = 0;
  logic signed [PSUM_W-1:0] drv_psm [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint relu_exp(input longint v);
`ifdef PE_DRAIN_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) macc[i] = 0;
    mfirst = 1;
    mq.delete();
    mtile = 0;
    msat = 0;
  endfunction

  task automatic drive_inputs();
    ifp.psm_0 = drv_psm[0]; ifp.psm_1 = drv_psm[1];
    ifp.psm_2 = drv_psm[2]; ifp.psm_3 = drv_psm[3];
    ifp.psm_4 = drv_psm[4]; ifp.psm_5 = drv_psm[5];
    ifp.psm_6 = drv_psm[6]; ifp.psm_7 = drv_psm[7];
    ifp.psm_valid = drv_valid;
    ifp.psm_last  = drv_last;
    ifo.out_ready = drv_ordy;
  endtask

  // One clock: check registered outputs, apply inputs, check psm_ready, advance model.
  task automatic step(output bit acc);
    beat_t  e;
    bit     mready;
    longint s;
    @(negedge clk);
    cyc++;
    chk("out_valid", longint'(ifo.out_valid), longint'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_ch", longint'(ifo.out_ch), longint'(mq[0].ch));
      chk("out_data", longint'(ifo.out_data), mq[0].data);
    end
    chk("tile_cnt", longint'(tile_cnt), longint'(mtile % (1 << TILE_CNT_W)));
    chk("sat_flag", longint'(sat_flag), longint'(msat));
    drive_inputs();
    #1;
    mready = !(mq.size() > 0 && drv_last);
    chk("psm_ready", longint'(ifp.psm_ready), longint'(mready));
    acc = drv_valid && mready && rst_n;
    if (rst_n && mq.size() > 0 && drv_ordy) begin
      e = mq.pop_front();
      e.cyc = cyc;
      seen.push_back(e);
      if (e.ch == 7) mtile++;
    end
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        s = mfirst ? longint'(drv_psm[i]) : macc[i] + longint'(drv_psm[i]);
        if (s > HI) begin s = HI; msat = 1; end
        if (s < LO) begin s = LO; msat = 1; end
        macc[i] = s;
      end
      mfirst = drv_last;
      if (drv_last) begin
        last_acc_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
          e.ch = i; e.data = relu_exp(macc[i]); e.cyc = 0;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic send(input bit last, input bit ordy);
    bit a = 0;
    drv_valid = 1; drv_last = last; drv_ordy = ordy;
    for (int k = 0; k < 200 && !a; k++) step(a);
    if (!a) chk("accept_timeout", 0, 1);
    drv_valid = 0; drv_last = 0;
  endtask

  task automatic drain();
    bit a;
    int k = 0;
    drv_valid = 0; drv_last = 0; drv_ordy = 1;
    while (mq.size() > 0 && k < 100) begin step(a); k++; end
    if (mq.size() > 0) chk("drain_timeout", 0, 1);
    step(a);
  endtask

  task automatic do_reset();
    bit a;
    drv_valid = 0; drv_last = 0; drv_ordy = 0;
    rst_n = 0;
    model_reset();
    step(a);
    step(a);
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int k, acc_cyc, ch7_cyc, nb, bad;
    logic signed [PSUM_W-1:0] bp [8];

    for (int i = 0; i < 8; i++) drv_psm[i] = '0;
    drive_inputs();

    // Reset state
    do_reset();
    chk("rst_out_data", longint'(ifo.out_data), 0);
    chk("rst_out_ch", longint'(ifo.out_ch), 0);
    chk("rst_out_valid", longint'(ifo.out_valid), 0);

    // 3-beat tile, psm_i = i+1
    seen.delete();
    for (int i = 0; i < 8; i++) drv_psm[i] = PSUM_W'(i + 1);
    for (int b = 0; b < 3; b++) send(b == 2, 1);
    acc_cyc = last_acc_cyc;
    drain();
    chk("t1_count", seen.size(), 8);
    for (int i = 0; i < seen.size() && i < 8; i++) begin
      chk("t1_ch", seen[i].ch, i);
      chk("t1_data", seen[i].data, 3 * (i + 1));
      chk("t1_cycle", seen[i].cyc, acc_cyc + 1 + i);
    end
    chk("t1_tile_cnt", longint'(tile_cnt), 1);

    // Single-beat tile with a negative channel
    seen.delete();
    for (int i = 0; i < 8; i++) drv_psm[i] = '0;
    drv_psm[3] = -32'sd5;
    send(1, 1);
    drain();
    chk("t2_count", seen.size(), 8);
    for (int i = 0; i < seen.size() && i < 8; i++) begin
`ifdef PE_DRAIN_RELU_EN
      chk("t2_data", seen[i].data, 0);
`else
      chk("t2_data", seen[i].data, (i == 3) ? -5 : 0);
`endif
    end

    // Saturation over 300 beats
    do_reset();
    seen.delete();
    for (int i = 0; i < 8; i++) drv_psm[i] = '0;
    drv_psm[0] = 32'sh7fffffff;
    for (int b = 0; b < 300; b++) send(b == 299, 1);
    drain();
    chk("t3_count", seen.size(), 8);
    if (seen.size() >= 2) begin
      chk("t3_ch0_clamp", seen[0].data, 64'sd549755813887);
      chk("t3_ch1", seen[1].data, 0);
    end
    chk("t3_sat", longint'(sat_flag), 1);
    for (int i = 0; i < 8; i++) drv_psm[i] = 32'sd1;
    send(1, 1);
    drain();
    chk("t3_sat_sticky", longint'(sat_flag), 1);

    // Backpressure and stalled second last beat
    do_reset();
    seen.delete();
    for (int i = 0; i < 8; i++) drv_psm[i] = PSUM_W'(10 * i + 1);
    send(1, 1);
    drv_ordy = 0;
    for (int c = 0; c < 5; c++) step(a);
    chk("t4_hold_ch", longint'(ifo.out_ch), 0);
    chk("t4_hold_valid", longint'(ifo.out_valid), 1);
    for (int i = 0; i < 8; i++) drv_psm[i] = -PSUM_W'(i + 2);
    drv_valid = 1; drv_last = 1;
    step(a);
    chk("t4_stall", a, 0);
    chk("t4_ready_low", longint'(ifp.psm_ready), 0);
    drv_ordy = 1;
    a = 0;
    for (k = 0; k < 50 && !a; k++) step(a);
    if (!a) chk("t4_accept_timeout", 0, 1);
    acc_cyc = last_acc_cyc;
    ch7_cyc = (seen.size() >= 8) ? seen[7].cyc : -100;
    chk("t4_accept_after_ch7", acc_cyc, ch7_cyc + 1);
    drain();
    chk("t4_count", seen.size(), 16);
    for (int i = 0; i < seen.size() && i < 16; i++) begin
      chk("t4_data", seen[i].data, (i < 8) ? 10 * i + 1 : relu_exp(-((i - 8) + 2)));
    end
    chk("t4_tile_cnt", longint'(tile_cnt), 2);

    // Reset in mid-drain at channel 4
    do_reset();
    for (int i = 0; i < 8; i++) drv_psm[i] = 32'sd1;
    send(1, 1);
    drain();
    for (int i = 0; i < 8; i++) drv_psm[i] = 32'sd2;
    send(1, 1);
    for (int i = 0; i < 8; i++) drv_psm[i] = 32'sd100;
    drv_ordy = 1; drv_valid = 1; drv_last = 0;
    k = 0;
    while (!(mq.size() > 0 && mq[0].ch == 4) && k < 20) begin step(a); k++; end
    chk("t5_reached_ch4", longint'(mq.size() > 0 && mq[0].ch == 4), 1);
    rst_n = 0;
    #1;
    chk("t5_rst_valid", longint'(ifo.out_valid), 0);
    chk("t5_rst_tile_cnt", longint'(tile_cnt), 0);
    model_reset();
    drv_valid = 0;
    step(a);
    rst_n = 1;
    seen.delete();
    for (int i = 0; i < 8; i++) drv_psm[i] = PSUM_W'(i);
    send(1, 1);
    drain();
    chk("t5_count", seen.size(), 8);
    for (int i = 0; i < seen.size() && i < 8; i++) chk("t5_fresh", seen[i].data, i);

    // Random traffic over 1000 tiles
    do_reset();
    seen.delete();
    for (int t = 0; t < 1000; t++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 8; i++) bp[i] = PSUM_W'($urandom);
        a = 0; k = 0;
        while (!a && k < 1000) begin
          drv_valid = ($urandom_range(0, 9) < 7);
          drv_ordy  = ($urandom_range(0, 9) < 6);
          drv_last  = (b == nb - 1);
          for (int i = 0; i < 8; i++) drv_psm[i] = drv_valid ? bp[i] : PSUM_W'($urandom);
          step(a);
          k++;
        end
        if (!a) chk("t6_accept_timeout", 0, 1);
      end
    end
    drain();
    chk("t6_count", seen.size(), 8000);
    bad = 0;
    for (int i = 0; i < seen.size(); i++) if (seen[i].ch != i % 8) bad++;
    chk("t6_order", bad, 0);
    chk("t6_tile_cnt", longint'(tile_cnt), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
